// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the systolic array controller.
//   state_t   : top-level sequencer states
//   cnt_width : width of the per-phase cycle counter, sized so that the
//               longest phase (M + 2N cycles at M = 2^CNT_W-1) never wraps
package array_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int cnt_width(input int cnt_w, input int n);
    int lg;
    lg = $clog2(n);
    return ((cnt_w > lg) ? cnt_w : lg) + 2;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Row skew generator for the systolic array compute enables.
// Tap 0 is the row-0 enable passed straight through; tap r is the same
// enable delayed by r cycles through an N-1 stage shift register.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear of every stage (used on abort)
//   din   : row-0 enable (already registered by the caller)
//   taps  : per-row enables, taps[r] = din delayed r cycles
module skew_line #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         din,
  output logic [N-1:0] taps
);

  if (N == 1) begin : g_none
    assign taps = din;
  end else begin : g_shift
    logic [N-1:1] stage_q;
    logic [N-1:1] stage_d;

    always_comb begin
      stage_d = '0;
      if (!clr) begin
        stage_d[1] = din;
        for (int r = 2; r < N; r++) begin
          stage_d[r] = stage_q[r-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign taps = {stage_q, din};
  end

endmodule

// File: rtl/systolic_array_controller.sv
// Sequencer for an N x N weight-stationary systolic array.
// On start it latches the run parameters, loads one weight row per cycle,
// streams M input vectors with per-row skew, and strobes the results out.
//   clk, reset_n          : clock / asynchronous active-low reset
//   start, abort          : run request (IDLE only) / synchronous abort
//   num_vecs              : M, vectors in this run (latched at start)
//   w_base/a_base/o_base  : buffer base addresses (latched at start)
//   busy, done            : run in progress / one-cycle completion pulse
//   w_rd_en, w_rd_addr    : weight buffer read
//   load_weight           : one-hot per-row weight load into the array
//   a_rd_en, a_rd_addr    : input buffer read
//   valid                 : per-row compute enable (skewed)
//   out_wr_en, out_wr_addr: output buffer write
// Every output is a flop; values are computed from the next state and the
// next counter value so they line up with the state they belong to.
module systolic_array_controller
  import array_ctrl_pkg::*;
#(
  parameter int N      = 2,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vecs,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] o_base,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic [N-1:0]      load_weight,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [N-1:0]      valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr
);

  localparam int            CW     = cnt_width(CNT_W, N);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] TWO_N  = CW'(2 * N);
  localparam logic [CW-1:0] LAST_K = CW'(N - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [ADDR_W-1:0]   w_base_q, w_base_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d;
  logic [ADDR_W-1:0]   o_base_q, o_base_d;
  logic [CW-1:0]       last_t;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                w_rd_en_q, w_rd_en_d;
  logic [ADDR_W-1:0]   w_rd_addr_q, w_rd_addr_d;
  logic [N-1:0]        load_weight_q, load_weight_d;
  logic                a_rd_en_q, a_rd_en_d;
  logic [ADDR_W-1:0]   a_rd_addr_q, a_rd_addr_d;
  logic                valid0_q, valid0_d;
  logic                out_wr_en_q, out_wr_en_d;
  logic [ADDR_W-1:0]   out_wr_addr_q, out_wr_addr_d;
  logic [CW-1:0]       m_d;
  logic                in_load_d, in_comp_d;

  // Final COMPUTE index: M + 2N - 1.
  assign last_t = CW'(num_q) + TWO_N - ONE;

  // ---------------- FSM and phase counter ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    o_base_d = o_base_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD_W;
          cnt_d    = '0;
          num_d    = num_vecs;
          w_base_d = w_base;
          a_base_d = a_base;
          o_base_d = o_base;
        end
      end
      LOAD_W: begin
        if (cnt_q == LAST_K) begin
          cnt_d   = '0;
          state_d = (num_q != '0) ? COMPUTE : DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      COMPUTE: begin
        if (cnt_q == last_t) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // ---------------- next-cycle output decode ----------------
  always_comb begin
    in_load_d = (state_d == LOAD_W);
    in_comp_d = (state_d == COMPUTE);
    m_d       = CW'(num_d);

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    w_rd_en_d   = in_load_d;
    w_rd_addr_d = in_load_d ? (w_base_d + ADDR_W'(cnt_d)) : '0;

    // Weight data returns one cycle after the read, so the row select
    // follows the read index of the current cycle.
    load_weight_d = ((state_q == LOAD_W) && !abort) ? (N'(1) << cnt_q) : '0;

    a_rd_en_d   = in_comp_d && (cnt_d < m_d);
    a_rd_addr_d = a_rd_en_d ? (a_base_d + ADDR_W'(cnt_d)) : '0;

    valid0_d = in_comp_d && (cnt_d >= ONE) && (cnt_d <= m_d);

    out_wr_en_d   = in_comp_d && (cnt_d >= TWO_N);
    out_wr_addr_d = out_wr_en_d ? (o_base_d + ADDR_W'(cnt_d - TWO_N)) : '0;
  end

  // ---------------- state and output registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      num_q         <= '0;
      w_base_q      <= '0;
      a_base_q      <= '0;
      o_base_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      w_rd_en_q     <= 1'b0;
      w_rd_addr_q   <= '0;
      load_weight_q <= '0;
      a_rd_en_q     <= 1'b0;
      a_rd_addr_q   <= '0;
      valid0_q      <= 1'b0;
      out_wr_en_q   <= 1'b0;
      out_wr_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      num_q         <= num_d;
      w_base_q      <= w_base_d;
      a_base_q      <= a_base_d;
      o_base_q      <= o_base_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      w_rd_en_q     <= w_rd_en_d;
      w_rd_addr_q   <= w_rd_addr_d;
      load_weight_q <= load_weight_d;
      a_rd_en_q     <= a_rd_en_d;
      a_rd_addr_q   <= a_rd_addr_d;
      valid0_q      <= valid0_d;
      out_wr_en_q   <= out_wr_en_d;
      out_wr_addr_q <= out_wr_addr_d;
    end
  end

  // ---------------- row skew: valid[r] = valid[0] delayed r ----------------
  skew_line #(
    .N (N)
  ) u_skew (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (abort),
    .din   (valid0_q),
    .taps  (valid)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign w_rd_en     = w_rd_en_q;
  assign w_rd_addr   = w_rd_addr_q;
  assign load_weight = load_weight_q;
  assign a_rd_en     = a_rd_en_q;
  assign a_rd_addr   = a_rd_addr_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_wr_addr = out_wr_addr_q;

endmodule

// File: tb/tb_systolic_array_controller.sv
// Self-checking bench for systolic_array_controller (N=2).
// The reference model derives each cycle's expected outputs from the run
// timeline: N load cycles, M+2N compute cycles (skipped when M=0), one done
// cycle, all indexed from the cycle after start is accepted.
module tb_systolic_array_controller;

  localparam int N      = 2;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_vecs;
  logic [ADDR_W-1:0] w_base, a_base, o_base;
  logic              busy, done, w_rd_en, a_rd_en, out_wr_en;
  logic [ADDR_W-1:0] w_rd_addr, a_rd_addr, out_wr_addr;
  logic [N-1:0]      load_weight, valid;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [N-1:0]      lw;
    logic              a_en;
    logic [ADDR_W-1:0] a_addr;
    logic [N-1:0]      vld;
    logic              o_en;
    logic [ADDR_W-1:0] o_addr;
  } outs_t;

  systolic_array_controller #(
    .N      (N),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .num_vecs    (num_vecs),
    .w_base      (w_base),
    .a_base      (a_base),
    .o_base      (o_base),
    .busy        (busy),
    .done        (done),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .load_weight (load_weight),
    .a_rd_en     (a_rd_en),
    .a_rd_addr   (a_rd_addr),
    .valid       (valid),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  // Expected outputs at cycle c of a run with M=m (cycle 0 follows the
  // accepting IDLE cycle). Beyond the done cycle everything is idle.
  function automatic outs_t exp_at(input int c, input int m,
                                   input logic [ADDR_W-1:0] wb,
                                   input logic [ADDR_W-1:0] ab,
                                   input logic [ADDR_W-1:0] ob);
    outs_t e;
    int    last_c;
    int    t;
    e      = '0;
    last_c = (m > 0) ? (N + m + 2 * N) : N;
    if (c < 0 || c > last_c) return e;
    e.busy = 1'b1;
    if (c == last_c) e.done = 1'b1;
    if (c < N) begin
      e.w_en   = 1'b1;
      e.w_addr = wb + ADDR_W'(c);
    end
    if (c >= 1 && c <= N) e.lw[c-1] = 1'b1;
    if (m > 0 && c >= N && c < last_c) begin
      t = c - N;
      if (t < m) begin
        e.a_en   = 1'b1;
        e.a_addr = ab + ADDR_W'(t);
      end
      for (int r = 0; r < N; r++) begin
        if (t >= 1 + r && t <= m + r) e.vld[r] = 1'b1;
      end
      if (t >= 2 * N) begin
        e.o_en   = 1'b1;
        e.o_addr = ob + ADDR_W'(t - 2 * N);
      end
    end
    return e;
  endfunction

  // Addresses are only meaningful while their strobe is expected high.
  task automatic check(input string tag, input outs_t e);
    outs_t o;
    o.busy   = busy;
    o.done   = done;
    o.w_en   = w_rd_en;
    o.w_addr = e.w_en ? w_rd_addr : '0;
    o.lw     = load_weight;
    o.a_en   = a_rd_en;
    o.a_addr = e.a_en ? a_rd_addr : '0;
    o.vld    = valid;
    o.o_en   = out_wr_en;
    o.o_addr = e.o_en ? out_wr_addr : '0;
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run from an IDLE cycle and checks cycles 0..done+1. Leaves the
  // bench in the IDLE cycle after done, where a new start may be accepted.
  task automatic run(input int m, input logic [ADDR_W-1:0] wb,
                     input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] ob,
                     input bit hold, input string tag);
    int last_c;
    num_vecs = CNT_W'(m);
    w_base   = wb;
    a_base   = ab;
    o_base   = ob;
    start    = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    // Parameters are latched; changing them mid-run must have no effect.
    num_vecs = CNT_W'($urandom);
    w_base   = ADDR_W'($urandom);
    a_base   = ADDR_W'($urandom);
    o_base   = ADDR_W'($urandom);
    last_c   = (m > 0) ? (N + m + 2 * N) : N;
    for (int c = 0; c <= last_c + 1; c++) begin
      check($sformatf("%s c%0d", tag, c), exp_at(c, m, wb, ab, ob));
      if (c <= last_c) tick();
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    num_vecs = '0;
    w_base   = '0;
    a_base   = '0;
    o_base   = '0;

    #2;
    check("reset_hold", '0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("reset_release", '0);

    // Directed run: N=2, M=3.
    run(3, 8'h10, 8'h20, 8'h30, 1'b0, "basic");
    // Empty run.
    run(0, 8'h44, 8'h55, 8'h66, 1'b0, "m0");
    // Input address wrap.
    run(4, 8'h00, 8'hFE, 8'hFD, 1'b0, "wrap");

    // start held through a run: one run, then the next begins after IDLE.
    run(2, 8'h01, 8'h02, 8'h03, 1'b1, "hold1");
    run(2, 8'h01, 8'h02, 8'h03, 1'b0, "hold2");

    // Abort during COMPUTE t=2.
    num_vecs = 8'd4;
    w_base   = 8'h08;
    a_base   = 8'h18;
    o_base   = 8'h28;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= N + 2; c++) begin
      check($sformatf("abort c%0d", c), exp_at(c, 4, 8'h08, 8'h18, 8'h28));
      if (c < N + 2) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_after%0d", i), '0);
      tick();
    end
    run(1, 8'hA0, 8'hB0, 8'hC0, 1'b0, "post_abort");

    // abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", '0);

    // Asynchronous reset in the middle of LOAD_W.
    num_vecs = 8'd3;
    w_base   = 8'h70;
    a_base   = 8'h71;
    o_base   = 8'h72;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("areset c0", exp_at(0, 3, 8'h70, 8'h71, 8'h72));
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_immediate", '0);
    #2;
    reset_n = 1'b1;
    tick();
    check("areset_after", '0);
    tick();
    run(3, 8'h90, 8'h91, 8'h92, 1'b0, "post_reset");

    // Randomized runs.
    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(0, 12)), ADDR_W'($urandom), ADDR_W'($urandom),
          ADDR_W'($urandom), 1'b0, $sformatf("rand%0d", i));
    end
    // Largest M: the counter must not wrap.
    run(255, ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 1'b0, "max_m");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
